// File: rtl/decoder3_8_pulse.sv
// decoder3_8_pulse
//   Sequenced 3-to-8 decoder. Codes arrive via a valid/ready handshake, are
//   buffered in a small FIFO and replayed one at a time as a one-hot strobe
//   on y, each held PULSE_LEN cycles and followed by at least one zero cycle.
//
// Ports
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   en        run enable; 0 freezes the pulse timer and blocks FIFO pops
//   in_valid  a holds a code to enqueue
//   a         3-bit code to decode
//   in_ready  FIFO can accept (not full, and not in reset)
//   y         registered one-hot strobe, 0 between strobes
//   done      one-cycle pulse in the cycle y returns to 0
//   busy      strobe active or FIFO non-empty
//   level     FIFO occupancy
module decoder3_8_pulse #(
   parameter int unsigned PULSE_LEN  = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          in_valid,
   input  logic [2:0]                    a,
   output logic                          in_ready,
   output logic [7:0]                    y,
   output logic                          done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int unsigned AW         = $clog2(FIFO_DEPTH);
   localparam logic [7:0]  TIMER_LOAD = 8'(PULSE_LEN - 1);
   localparam logic [AW:0] FULL_LEVEL = FIFO_DEPTH[AW:0];

   typedef enum logic {
      IDLE,
      ACTIVE
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      timer_q, timer_d;
   logic [7:0]      y_q, y_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic [AW:0]     level_q, level_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [2:0]      mem_q [FIFO_DEPTH];
   logic [2:0]      mem_d [FIFO_DEPTH];
   logic            push;
   logic            pop;

   // No full bypass: readiness depends only on the registered occupancy.
   assign in_ready = rst_n && (level_q != FULL_LEVEL);

   always_comb begin
      push     = in_valid && in_ready;
      pop      = (state_q == IDLE) && en && (level_q != '0);

      state_d  = state_q;
      timer_d  = timer_q;
      y_d      = y_q;
      done_d   = 1'b0;
      level_d  = level_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;

      if (push) begin
         mem_d[wr_ptr_q] = a;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      case (state_q)
         IDLE: begin
            if (pop) begin
               y_d     = 8'b1 << mem_q[rd_ptr_q];
               timer_d = TIMER_LOAD;
               state_d = ACTIVE;
            end
         end
         ACTIVE: begin
            // en=0 leaves timer and y untouched, stretching the strobe.
            if (en) begin
               if (timer_q != '0) begin
                  timer_d = timer_q - 8'd1;
               end else begin
                  y_d     = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
      endcase

      busy_d = (state_d == ACTIVE) || (level_d != '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         y_q      <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         y_q      <= y_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         level_q  <= level_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign y     = y_q;
   assign done  = done_q;
   assign busy  = busy_q;
   assign level = level_q;

endmodule

// File: doc/decoder3_8_pulse.md
# decoder3_8_pulse

Sequenced 3-to-8 decoder. Accepts a stream of 3-bit codes through a valid/ready handshake and buffers them in a small FIFO. It drives each code as a one-hot `y` strobe held for PULSE_LEN cycles, with a guaranteed all-zero cycle between strobes. It sits downstream of the 8-to-3 priority/plain encoders and regenerates one-hot select lines, for example for LED, row or chip-select drive, from encoded indices.

## Interface
- PULSE_LEN, 4: cycles each one-hot output is held; legal range 1..255.
- FIFO_DEPTH, 4: code buffer entries; power of two, 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset; sampled on `clk` rising edge.
- en  input  1  global run enable; 0 freezes the pulse timer and blocks FIFO pops.
- in_valid  input  1  `a` holds a code to enqueue.
- a  input  3  binary code, 0..7.
- in_ready  output  1  FIFO can accept; equals !full, forced 0 while rst_n=0.
- y  output  8  registered one-hot decode, y = 1<<code while active, else 8'h00.
- done  output  1  one-cycle pulse in the cycle `y` returns to 0 after a strobe.
- busy  output  1  state ACTIVE or FIFO non-empty (registered terms only).
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: an edge with in_valid & in_ready writes `a` to the FIFO tail and increments `level`.
- While full, in_ready=0, even if a pop occurs on the same edge. There is no same-cycle full bypass.
- Push while empty: there is no bypass to `y`. The code is popped at the earliest on the following edge.
- FSM states are IDLE and ACTIVE.
- IDLE: `y`=0. On an edge with en=1 and level>0, pop the head, load y <= 1<<head and timer <= PULSE_LEN-1, then go to ACTIVE.
- ACTIVE, en=1, timer>0: decrement the timer; `y` holds.
- ACTIVE, en=1, timer==0: y <= 0, done <= 1, go to IDLE.
- ACTIVE, en=0: timer and `y` freeze. The pulse is stretched by exactly the number of en=0 cycles.
- IDLE, en=0: no pop. Pushes still accepted.
- Simultaneous push and pop: `level` is unchanged, and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Timer is 8 bits. `y` is always one-hot or zero, never multi-hot.
- `done` is high only in the cycle after the ACTIVE→IDLE edge. It is 0 otherwise.

## Timing
- Reset values: y=8'h00, done=0, busy=0, level=0, state IDLE, timer=0, pointers=0, in_ready=0 while rst_n=0 and 1 on the first cycle after release.
- Reset mid-pulse aborts the strobe and discards all buffered codes. No `done` is issued.
- Latency: a code accepted on edge E0 into an empty FIFO with state IDLE and en=1 gives `y` valid after edge E0+1.
- `y` stays high for PULSE_LEN cycles, through edge E0+PULSE_LEN. It returns to 0 with done=1 after edge E0+PULSE_LEN+1.
- Throughput with the FIFO never empty and en=1: one code per PULSE_LEN+1 cycles. Every strobe is separated by exactly one zero cycle.
- All outputs are registered except in_ready, which is combinational from `level` and rst_n.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-strobe with level=2. Required: y=00, done=0, busy=0, level=0, in_ready=0 during reset, and in_ready=1 on the first cycle after release.
- Single code, PULSE_LEN=4: push a=5 on edge E0. Required: y=8'h20 after edges E0+1..E0+4, then y=00 with done=1 after E0+5, then busy=0.
- Burst, FIFO_DEPTH=4: hold in_valid=1 with codes 0..7. Required: in_ready=0 whenever level=4; y sequence 01,02,04,08,10,20,40,80, each 4 cycles with one 00 cycle between; 40 cycles total; 8 done pulses.
- Enable: drop en for 3 cycles mid-strobe. Required: `y` is held and the strobe lasts 7 cycles. With en=0 in IDLE and level=1, `y` stays 00 and `level` stays 1 until en=1.
- Full boundary: with level=4 and a pop due on the same edge, in_valid=1. Required: no accept on that edge (`level` drops to 3); the code is accepted on the next edge (`level` returns to 4).
- PULSE_LEN=1: push codes 2 then 6. Required: y=04 for 1 cycle, 00 for 1 cycle with done=1, 40 for 1 cycle, then 00 with done=1.
